uart_prot_rx_seq: RTL and testbench
===================================

Name: uart_prot_rx_seq

Overview:
- Receive-side protocol sequencer for the UART protocol layer; it is the counterpart of the TX sequencer that emits slave address, payload bytes and stop frame.
- It consumes bytes from the UART core receiver and matches the first byte against self_addr.
- On a match it forwards payload bytes into the config block's RX FIFO until stop_frame arrives, then pulses rx_rst to clear Rx_en.
- It also reports per-frame length and error status to the user side.

Parameters:
MAX_PAYLOAD, 16, maximum payload bytes per frame (1..255).
TIMEOUT_W, 16, width of the inter-byte timeout counter.
TIMEOUT_CYC, 50000, glb_clk cycles allowed between bytes inside a frame.

Ports:
glb_clk  input  1  system clock, all logic on its rising edge.
glb_rstn  input  1  asynchronous active-low reset.
CFG_PROT_ctrl_rxen  input  1  receive enable from the config block.
CFG_PROT_data_self_addr  input  8  own node address.
CFG_PROT_data_stop_frame  input  8  frame terminator value.
CORE_PROT_ctrl_rx_valid  input  1  one-cycle pulse, a received byte is present.
CORE_PROT_data_rx_data  input  8  received byte, valid with rx_valid.
CORE_PROT_ctrl_parity_err  input  1  parity error for the current byte, valid with rx_valid.
Rx_FIFO_full  input  1  RX FIFO full flag.
PROT_CFG_ctrl_rx_w_en  output  1  RX FIFO write strobe.
PROT_CFG_data_rx_data  output  8  byte to write, valid with w_en.
PROT_CFG_ctrl_rx_rst  output  1  one-cycle pulse that clears Rx_en.
PROT_USR_ctrl_frame_done  output  1  one-cycle pulse, frame accepted and terminated.
PROT_USR_data_frame_len  output  8  payload bytes written in the last or current frame.
PROT_USR_stat_err  output  4  sticky bits {timeout, len_err, parity_err, overflow}.

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0.
- Outputs are registered. A byte with rx_valid in cycle N produces w_en and data in cycle N+1.
- IDLE: while rxen=1 go to WAIT_ADDR; on entry clear frame_len and stat_err.
- WAIT_ADDR: no timeout.
  - On rx_valid with no parity error and byte == self_addr, go to PAYLOAD.
  - On rx_valid with any other byte, or with a parity error, go to SKIP.
- PAYLOAD, on rx_valid:
  - Byte == stop_frame (with or without a parity error): go to DONE. The stop byte is never written.
  - Else parity_err=1: set stat_err[1], drop the byte.
  - Else Rx_FIFO_full=1: set stat_err[0], drop the byte.
  - Else frame_len == MAX_PAYLOAD: set stat_err[2], go to SKIP.
  - Otherwise: assert w_en and increment frame_len.
- SKIP: discard bytes. On rx_valid with byte == stop_frame, go to ABORT.
- DONE (one cycle): pulse rx_rst and frame_done, then go to IDLE.
- ABORT (one cycle): pulse rx_rst only, then go to IDLE.
- Timeout counter: runs in PAYLOAD and SKIP and clears on every rx_valid. When it reaches TIMEOUT_CYC-1, set stat_err[3] and go to ABORT.
- rxen dropping to 0 in any state other than DONE or ABORT returns to IDLE next cycle with no rx_rst pulse. stat_err and frame_len are held.
- stat_err and frame_len hold their values until the next entry into WAIT_ADDR.
- rx_valid in DONE, ABORT or IDLE is ignored.
- frame_len never exceeds MAX_PAYLOAD.
- rx_rst and w_en are never asserted in the same cycle.

Optional Feature:
- Macro: UART_PROT_BCAST_EN.
- Defined: WAIT_ADDR also accepts address 8'hFF as a match. A broadcast frame runs normally but ends in ABORT-style termination: rx_rst pulses, frame_done does not, and bytes are still written.
- Undefined: only self_addr matches; 8'hFF is treated as any other non-matching address.

Decomposition:
- Package uart_prot_pkg holds:
  - the state encoding {IDLE, WAIT_ADDR, PAYLOAD, SKIP, DONE, ABORT};
  - BCAST_ADDR = 8'hFF;
  - stat_err bit indices ERR_OVF=0, ERR_PAR=1, ERR_LEN=2, ERR_TMO=3.
- One sub-module, uart_prot_timeout: loadable up-counter with clear, enable and a terminal-count pulse, parameterised by TIMEOUT_W and TIMEOUT_CYC.

Test Plan:
- self_addr=8'h12, stop=8'h0D; send 12,41,42,0D → w_en twice with data 41,42; frame_len=2; frame_done and rx_rst pulse once; stat_err=0.
- Send 34,41,0D with self_addr=12 → no w_en; rx_rst pulses, frame_done does not.
- Send 12,41(parity_err),42,0D → one write of 42; stat_err=4'b0010; frame_done=1.
- Rx_FIFO_full=1 during byte 43 of 12,41,43,0D → 41 written, 43 dropped; stat_err=4'b0001.
- TIMEOUT_CYC=100; send 12,41, then silence → after 100 cycles stat_err[3]=1, rx_rst pulses, state IDLE; MAX_PAYLOAD=2 with 12,1,2,3,0D → stat_err[2]=1, frame_len=2, termination via ABORT.
- Assert glb_rstn low mid-PAYLOAD → all outputs 0 immediately; after release the next valid frame completes normally.

Source files
------------

// File: rtl/uart_prot_pkg.sv
// Shared types and constants for the UART protocol receive sequencer.
// Macro UART_PROT_BCAST_EN widens the address match to include the broadcast address.
package uart_prot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_ADDR = 3'd1,
    ST_PAYLOAD   = 3'd2,
    ST_SKIP      = 3'd3,
    ST_DONE      = 3'd4,
    ST_ABORT     = 3'd5
  } prot_state_e;

  localparam logic [7:0] BCAST_ADDR = 8'hFF;

  localparam int ERR_OVF = 0;
  localparam int ERR_PAR = 1;
  localparam int ERR_LEN = 2;
  localparam int ERR_TMO = 3;

  // Address byte acceptance, including broadcast when that build option is on
  function automatic logic addr_match(input logic [7:0] rx_byte, input logic [7:0] self_addr);
`ifdef UART_PROT_BCAST_EN
    return (rx_byte == self_addr) || (rx_byte == BCAST_ADDR);
`else
    return (rx_byte == self_addr);
`endif
  endfunction

endpackage

// File: rtl/uart_prot_timeout.sv
// Inter-byte timeout counter: loadable up-counter with clear/enable and a
// terminal-count pulse raised while the count sits at TIMEOUT_CYC-1.
module uart_prot_timeout #(
  parameter int TIMEOUT_W   = 16,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                 glb_clk,
  input  logic                 glb_rstn,
  input  logic                 clr,
  input  logic                 en,
  input  logic                 load,
  input  logic [TIMEOUT_W-1:0] load_val,
  output logic                 tc
);

  localparam logic [TIMEOUT_W-1:0] TC_VAL = TIMEOUT_W'(TIMEOUT_CYC - 1);
  localparam logic [TIMEOUT_W-1:0] ONE    = TIMEOUT_W'(1);

  logic [TIMEOUT_W-1:0] count_r;

  // Count register: clear dominates load, load dominates increment
  always_ff @(posedge glb_clk or negedge glb_rstn) begin
    if (!glb_rstn) begin
      count_r <= {TIMEOUT_W{1'b0}};
    end else if (clr) begin
      count_r <= {TIMEOUT_W{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (en) begin
      count_r <= count_r + ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign tc = en & ~clr & ~load & (count_r == TC_VAL);

endmodule

// File: rtl/uart_prot_rx_seq.sv
// Receive-side protocol sequencer: address match, payload forwarding to the RX FIFO,
// stop-frame termination and error reporting. Macro UART_PROT_BCAST_EN enables broadcast.
module uart_prot_rx_seq #(
  parameter int MAX_PAYLOAD = 16,
  parameter int TIMEOUT_W   = 16,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       glb_clk,
  input  logic       glb_rstn,
  input  logic       CFG_PROT_ctrl_rxen,
  input  logic [7:0] CFG_PROT_data_self_addr,
  input  logic [7:0] CFG_PROT_data_stop_frame,
  input  logic       CORE_PROT_ctrl_rx_valid,
  input  logic [7:0] CORE_PROT_data_rx_data,
  input  logic       CORE_PROT_ctrl_parity_err,
  input  logic       Rx_FIFO_full,
  output logic       PROT_CFG_ctrl_rx_w_en,
  output logic [7:0] PROT_CFG_data_rx_data,
  output logic       PROT_CFG_ctrl_rx_rst,
  output logic       PROT_USR_ctrl_frame_done,
  output logic [7:0] PROT_USR_data_frame_len,
  output logic [3:0] PROT_USR_stat_err
);

  import uart_prot_pkg::*;

  localparam logic [7:0] MAX_LEN = 8'(MAX_PAYLOAD);

  prot_state_e state_r;
  logic [7:0]  frame_len_r;
  logic [3:0]  stat_err_r;
  logic        w_en_r;
  logic [7:0]  w_data_r;
  logic        rx_rst_r;
  logic        frame_done_r;
`ifdef UART_PROT_BCAST_EN
  logic        bcast_r;
`endif

  logic tmo_clr_s;
  logic tmo_en_s;
  logic tmo_tc_s;
  logic is_stop_s;

  assign is_stop_s = (CORE_PROT_data_rx_data == CFG_PROT_data_stop_frame);

  // Timer runs only inside a frame body; every received byte restarts it
  always_comb begin
    tmo_en_s  = 1'b0;
    tmo_clr_s = 1'b1;
    if (CFG_PROT_ctrl_rxen && ((state_r == ST_PAYLOAD) || (state_r == ST_SKIP))) begin
      tmo_en_s  = 1'b1;
      tmo_clr_s = 1'b0;
    end else begin
      tmo_en_s  = 1'b0;
      tmo_clr_s = 1'b1;
    end
  end

  uart_prot_timeout #(
    .TIMEOUT_W   (TIMEOUT_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .glb_clk  (glb_clk),
    .glb_rstn (glb_rstn),
    .clr      (tmo_clr_s),
    .en       (tmo_en_s),
    .load     (CORE_PROT_ctrl_rx_valid),
    .load_val ({TIMEOUT_W{1'b0}}),
    .tc       (tmo_tc_s)
  );

  // Sequencer FSM; strobes default low and are raised on the transition that owns them
  always_ff @(posedge glb_clk or negedge glb_rstn) begin
    if (!glb_rstn) begin
      state_r      <= ST_IDLE;
      frame_len_r  <= 8'd0;
      stat_err_r   <= 4'd0;
      w_en_r       <= 1'b0;
      w_data_r     <= 8'd0;
      rx_rst_r     <= 1'b0;
      frame_done_r <= 1'b0;
`ifdef UART_PROT_BCAST_EN
      bcast_r      <= 1'b0;
`endif
    end else begin
      w_en_r       <= 1'b0;
      rx_rst_r     <= 1'b0;
      frame_done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (CFG_PROT_ctrl_rxen) begin
            state_r     <= ST_WAIT_ADDR;
            frame_len_r <= 8'd0;
            stat_err_r  <= 4'd0;
`ifdef UART_PROT_BCAST_EN
            bcast_r     <= 1'b0;
`endif
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_WAIT_ADDR: begin
          if (!CFG_PROT_ctrl_rxen) begin
            state_r <= ST_IDLE;
          end else if (CORE_PROT_ctrl_rx_valid) begin
            if (!CORE_PROT_ctrl_parity_err &&
                addr_match(CORE_PROT_data_rx_data, CFG_PROT_data_self_addr)) begin
              state_r <= ST_PAYLOAD;
`ifdef UART_PROT_BCAST_EN
              bcast_r <= (CORE_PROT_data_rx_data == BCAST_ADDR);
`endif
            end else begin
              state_r <= ST_SKIP;
            end
          end else begin
            state_r <= ST_WAIT_ADDR;
          end
        end
        ST_PAYLOAD: begin
          if (!CFG_PROT_ctrl_rxen) begin
            state_r <= ST_IDLE;
          end else if (CORE_PROT_ctrl_rx_valid) begin
            if (is_stop_s) begin
              rx_rst_r <= 1'b1;
`ifdef UART_PROT_BCAST_EN
              // Broadcast frames terminate without reporting completion
              state_r      <= bcast_r ? ST_ABORT : ST_DONE;
              frame_done_r <= ~bcast_r;
`else
              state_r      <= ST_DONE;
              frame_done_r <= 1'b1;
`endif
            end else if (CORE_PROT_ctrl_parity_err) begin
              stat_err_r[ERR_PAR] <= 1'b1;
            end else if (Rx_FIFO_full) begin
              stat_err_r[ERR_OVF] <= 1'b1;
            end else if (frame_len_r == MAX_LEN) begin
              stat_err_r[ERR_LEN] <= 1'b1;
              state_r             <= ST_SKIP;
            end else begin
              w_en_r      <= 1'b1;
              w_data_r    <= CORE_PROT_data_rx_data;
              frame_len_r <= frame_len_r + 8'd1;
            end
          end else if (tmo_tc_s) begin
            stat_err_r[ERR_TMO] <= 1'b1;
            rx_rst_r            <= 1'b1;
            state_r             <= ST_ABORT;
          end else begin
            state_r <= ST_PAYLOAD;
          end
        end
        ST_SKIP: begin
          if (!CFG_PROT_ctrl_rxen) begin
            state_r <= ST_IDLE;
          end else if (CORE_PROT_ctrl_rx_valid && is_stop_s) begin
            rx_rst_r <= 1'b1;
            state_r  <= ST_ABORT;
          end else if (tmo_tc_s) begin
            stat_err_r[ERR_TMO] <= 1'b1;
            rx_rst_r            <= 1'b1;
            state_r             <= ST_ABORT;
          end else begin
            state_r <= ST_SKIP;
          end
        end
        ST_DONE:  state_r <= ST_IDLE;
        ST_ABORT: state_r <= ST_IDLE;
        default:  state_r <= ST_IDLE;
      endcase
    end
  end

  assign PROT_CFG_ctrl_rx_w_en    = w_en_r;
  assign PROT_CFG_data_rx_data    = w_data_r;
  assign PROT_CFG_ctrl_rx_rst     = rx_rst_r;
  assign PROT_USR_ctrl_frame_done = frame_done_r;
  assign PROT_USR_data_frame_len  = frame_len_r;
  assign PROT_USR_stat_err        = stat_err_r;

endmodule

// File: tb/tb_uart_prot_rx_seq.sv
// Self-checking bench for uart_prot_rx_seq: frame-level reference model checked every
// cycle, plus hand-computed per-frame expectations.
module tb_uart_prot_rx_seq;

  localparam int MAXP = 2;
  localparam int TCYC = 100;
  localparam logic [7:0] SELF = 8'h12;
  localparam logic [7:0] STOP = 8'h0D;

  logic       glb_clk;
  logic       glb_rstn;
  logic       rxen;
  logic [7:0] self_addr;
  logic [7:0] stop_frame;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       parity_err;
  logic       fifo_full;
  logic       w_en;
  logic [7:0] w_data;
  logic       rx_rst;
  logic       frame_done;
  logic [7:0] frame_len;
  logic [3:0] stat_err;

  int n_chk  = 0;
  int n_fail = 0;
  int n_rst  = 0;
  int n_done = 0;
  logic [7:0] wq[$];

  uart_prot_rx_seq #(.MAX_PAYLOAD(MAXP), .TIMEOUT_W(16), .TIMEOUT_CYC(TCYC)) dut (
    .glb_clk                  (glb_clk),
    .glb_rstn                 (glb_rstn),
    .CFG_PROT_ctrl_rxen       (rxen),
    .CFG_PROT_data_self_addr  (self_addr),
    .CFG_PROT_data_stop_frame (stop_frame),
    .CORE_PROT_ctrl_rx_valid  (rx_valid),
    .CORE_PROT_data_rx_data   (rx_data),
    .CORE_PROT_ctrl_parity_err(parity_err),
    .Rx_FIFO_full             (fifo_full),
    .PROT_CFG_ctrl_rx_w_en    (w_en),
    .PROT_CFG_data_rx_data    (w_data),
    .PROT_CFG_ctrl_rx_rst     (rx_rst),
    .PROT_USR_ctrl_frame_done (frame_done),
    .PROT_USR_data_frame_len  (frame_len),
    .PROT_USR_stat_err        (stat_err)
  );

  initial glb_clk = 1'b0;
  always #5 glb_clk = ~glb_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: where we are in a frame, what the next cycle's outputs must be
  typedef struct packed {
    logic        listening;
    logic        in_frame;
    logic        skipping;
    logic        closing;
    logic [31:0] silence;
    logic        wen;
    logic [7:0]  data;
    logic        rst;
    logic        done;
    logic [7:0]  len;
    logic [3:0]  err;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t step(input mdl_t s, input logic en, input logic v,
                                input logic [7:0] d, input logic pe, input logic fu);
    mdl_t n = s;
    n.wen  = 1'b0;
    n.rst  = 1'b0;
    n.done = 1'b0;
    if (s.closing) begin
      n.closing = 1'b0;
    end else if (!s.listening && !s.in_frame && !s.skipping) begin
      if (en) begin
        n.listening = 1'b1;
        n.len       = 8'd0;
        n.err       = 4'd0;
      end
    end else if (!en) begin
      n.listening = 1'b0;
      n.in_frame  = 1'b0;
      n.skipping  = 1'b0;
    end else if (s.listening) begin
      if (v) begin
        n.listening = 1'b0;
        n.silence   = 32'd0;
        if (!pe && d == SELF) n.in_frame = 1'b1;
        else n.skipping = 1'b1;
      end
    end else if (v) begin
      n.silence = 32'd0;
      if (d == STOP) begin
        n.closing  = 1'b1;
        n.rst      = 1'b1;
        n.done     = s.in_frame;
        n.in_frame = 1'b0;
        n.skipping = 1'b0;
      end else if (s.in_frame) begin
        if (pe) n.err[1] = 1'b1;
        else if (fu) n.err[0] = 1'b1;
        else if (s.len == 8'(MAXP)) begin
          n.err[2]   = 1'b1;
          n.in_frame = 1'b0;
          n.skipping = 1'b1;
        end else begin
          n.wen  = 1'b1;
          n.data = d;
          n.len  = s.len + 8'd1;
        end
      end
    end else if (s.silence == 32'(TCYC - 1)) begin
      n.err[3]   = 1'b1;
      n.closing  = 1'b1;
      n.rst      = 1'b1;
      n.in_frame = 1'b0;
      n.skipping = 1'b0;
    end else begin
      n.silence = s.silence + 32'd1;
    end
    return n;
  endfunction

  always @(posedge glb_clk or negedge glb_rstn) begin
    if (!glb_rstn) m <= '0;
    else m <= step(m, rxen, rx_valid, rx_data, parity_err, fifo_full);
  end

  // Per-cycle compare against the model, plus capture for frame-level checks
  always @(negedge glb_clk) begin
    if (glb_rstn) begin
      chk("w_en", 32'(w_en), 32'(m.wen));
      if (m.wen) chk("w_data", 32'(w_data), 32'(m.data));
      chk("rx_rst", 32'(rx_rst), 32'(m.rst));
      chk("frame_done", 32'(frame_done), 32'(m.done));
      chk("frame_len", 32'(frame_len), 32'(m.len));
      chk("stat_err", 32'(stat_err), 32'(m.err));
      if (w_en) wq.push_back(w_data);
      if (rx_rst) n_rst++;
      if (frame_done) n_done++;
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic pe, input logic fu);
    rx_valid   = 1'b1;
    rx_data    = b;
    parity_err = pe;
    fifo_full  = fu;
    @(posedge glb_clk) #1;
    rx_valid   = 1'b0;
    parity_err = 1'b0;
    fifo_full  = 1'b0;
  endtask

  // Bytes packed first-in-LSB; drop_en mimics the config block clearing Rx_en
  task automatic send_frame(input int n, input logic [63:0] bv, input logic [7:0] pe_m,
                            input logic [7:0] fu_m, input bit drop_en);
    rxen = 1'b1;
    @(posedge glb_clk) #1;
    for (int i = 0; i < n; i++) begin
      send_byte(bv[8*i +: 8], pe_m[i], fu_m[i]);
      if (drop_en && i == n - 1) rxen = 1'b0;
      @(posedge glb_clk) #1;
    end
  endtask

  int b_w, b_r, b_d;

  task automatic mark;
    b_w = wq.size();
    b_r = n_rst;
    b_d = n_done;
  endtask

  task automatic check_frame(input string nm, input int nw, input logic [7:0] w0,
                             input logic [7:0] w1, input int nr, input int nd,
                             input logic [3:0] err, input logic [7:0] len);
    repeat (3) @(posedge glb_clk);
    #1;
    chk({nm, ".writes"}, 32'(wq.size() - b_w), 32'(nw));
    if (nw > 0 && wq.size() > b_w) chk({nm, ".wdata0"}, 32'(wq[b_w]), 32'(w0));
    if (nw > 1 && wq.size() > b_w + 1) chk({nm, ".wdata1"}, 32'(wq[b_w + 1]), 32'(w1));
    chk({nm, ".rx_rst"}, 32'(n_rst - b_r), 32'(nr));
    chk({nm, ".done"}, 32'(n_done - b_d), 32'(nd));
    chk({nm, ".stat_err"}, 32'(stat_err), 32'(err));
    chk({nm, ".frame_len"}, 32'(frame_len), 32'(len));
  endtask

  int cnt;

  initial begin
    glb_rstn = 1'b0; rxen = 1'b0; self_addr = SELF; stop_frame = STOP;
    rx_valid = 1'b0; rx_data = 8'd0; parity_err = 1'b0; fifo_full = 1'b0;
    repeat (3) @(posedge glb_clk);
    #1;
    chk("reset.outs", 32'({w_en, w_data, rx_rst, frame_done, frame_len, stat_err}), 32'd0);
    glb_rstn = 1'b1;
    @(posedge glb_clk) #1;

    mark(); send_frame(4, 64'h0D424112, 8'h00, 8'h00, 1'b1);
    check_frame("basic", 2, 8'h41, 8'h42, 1, 1, 4'b0000, 8'd2);

    mark(); send_frame(3, 64'h0D4134, 8'h00, 8'h00, 1'b1);
    check_frame("other_addr", 0, 8'h00, 8'h00, 1, 0, 4'b0000, 8'd0);

    mark(); send_frame(4, 64'h0D424112, 8'h02, 8'h00, 1'b1);
    check_frame("parity", 1, 8'h42, 8'h00, 1, 1, 4'b0010, 8'd1);

    mark(); send_frame(4, 64'h0D434112, 8'h00, 8'h04, 1'b1);
    check_frame("fifo_full", 1, 8'h41, 8'h00, 1, 1, 4'b0001, 8'd1);

    mark(); send_frame(5, 64'h0D03020112, 8'h00, 8'h00, 1'b1);
    check_frame("max_len", 2, 8'h01, 8'h02, 1, 0, 4'b0100, 8'd2);

    mark(); send_frame(2, 64'h0D12, 8'h00, 8'h00, 1'b1);
    check_frame("empty", 0, 8'h00, 8'h00, 1, 1, 4'b0000, 8'd0);

    // Silence after a payload byte must expire the frame
    mark(); send_frame(2, 64'h4112, 8'h00, 8'h00, 1'b0);
    cnt = 0;
    while (cnt < 300 && rx_rst !== 1'b1) begin
      @(negedge glb_clk);
      cnt++;
    end
    chk("timeout.cycles", 32'(cnt), 32'd100);
    rxen = 1'b0;
    check_frame("timeout", 1, 8'h41, 8'h00, 1, 0, 4'b1000, 8'd1);

    mark(); send_frame(2, 64'h4112, 8'h00, 8'h00, 1'b1);
    send_byte(8'h55, 1'b0, 1'b0);
    check_frame("rxen_drop", 1, 8'h41, 8'h00, 0, 0, 4'b0000, 8'd1);

    // Asynchronous reset in the middle of a frame
    mark(); send_frame(2, 64'h4112, 8'h00, 8'h00, 1'b0);
    #2 glb_rstn = 1'b0;
    #1;
    chk("midreset.outs", 32'({w_en, w_data, rx_rst, frame_done, frame_len, stat_err}), 32'd0);
    rxen = 1'b0;
    repeat (2) @(posedge glb_clk);
    #1 glb_rstn = 1'b1;
    @(posedge glb_clk) #1;
    mark(); send_frame(4, 64'h0D424112, 8'h00, 8'h00, 1'b1);
    check_frame("after_reset", 2, 8'h41, 8'h42, 1, 1, 4'b0000, 8'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
